// File: rtl/div_iter_hs.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_hs
// Purpose  : Restoring radix-2 divider (DIV/DIVU) with valid/ready handshakes,
//            optional leading-zero skip, divide-by-zero detection and flush.
// Revision : 1.0  initial release
// ============================================================================
module div_iter_hs #(
  parameter int WIDTH       = 32,
  parameter int EARLY_TERM  = 1,
  parameter int COUNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] c_width = COUNT_WIDTH'(WIDTH);
  localparam logic [COUNT_WIDTH-1:0] c_one   = COUNT_WIDTH'(1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       r_rem;
  logic [WIDTH-1:0]       r_dvd;
  logic [WIDTH-1:0]       r_dvs;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic                   r_neg_q;
  logic                   r_neg_r;
  logic [WIDTH-1:0]       r_quotient;
  logic [WIDTH-1:0]       r_remainder;
  logic                   r_dbz;

  logic                   w_accept;
  logic [WIDTH-1:0]       w_dvd_abs;
  logic [WIDTH-1:0]       w_dvs_abs;
  logic [COUNT_WIDTH-1:0] w_clz;
  logic [COUNT_WIDTH-1:0] w_iter;
  logic [COUNT_WIDTH-1:0] w_shamt;
  logic [WIDTH:0]         w_shift;
  logic [WIDTH:0]         w_diff;
  logic                   w_ge;
  logic [WIDTH-1:0]       w_rem_nxt;
  logic [WIDTH-1:0]       w_quo_nxt;
  logic                   w_last_step;

  function automatic logic [COUNT_WIDTH-1:0] f_clz(input logic [WIDTH-1:0] v);
    logic [COUNT_WIDTH-1:0] n;
    n = COUNT_WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) n = COUNT_WIDTH'(WIDTH - 1 - i);
    end
    return n;
  endfunction

  assign in_ready    = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept    = in_valid & in_ready & ~flush;
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state == S_CALC);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

  // Operand preparation: magnitudes and the number of steps actually needed
  always_comb begin
    w_dvd_abs = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
    w_dvs_abs = (is_signed & divisor[WIDTH-1])  ? -divisor  : divisor;
    w_clz     = f_clz(w_dvd_abs);
    w_iter    = c_width;
    w_shamt   = '0;
    if (divisor == '0) begin
      w_iter = '0;
    end else if (EARLY_TERM != 0) begin
      if (w_clz == c_width) begin
        w_iter = c_one;
      end else begin
        w_iter  = c_width - w_clz;
        w_shamt = w_clz;
      end
    end
  end

  // One restoring step; the partial remainder is always below |divisor|,
  // so the WIDTH+1 bit difference cannot overflow.
  always_comb begin
    w_shift     = {r_rem, r_dvd[WIDTH-1]};
    w_diff      = w_shift - {1'b0, r_dvs};
    w_ge        = ~w_diff[WIDTH];
    w_rem_nxt   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_nxt   = {r_dvd[WIDTH-2:0], w_ge};
    w_last_step = (r_state == S_CALC) & (r_cnt == c_one);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_iter == '0) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == c_one) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_accept)       w_state_nxt = (w_iter == '0) ? S_DONE : S_CALC;
        else if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rem   <= '0;
        r_dvd   <= w_dvd_abs << w_shamt;
        r_dvs   <= w_dvs_abs;
        r_cnt   <= w_iter;
        r_neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        r_neg_r <= is_signed & dividend[WIDTH-1];
        if (w_iter == '0) begin
          r_quotient  <= '1;
          r_remainder <= dividend;
          r_dbz       <= 1'b1;
        end
      end else if (flush) begin
        r_cnt <= '0;
      end else if (r_state == S_CALC) begin
        r_rem <= w_rem_nxt;
        r_dvd <= w_quo_nxt;
        r_cnt <= r_cnt - c_one;
        if (w_last_step) begin
          r_quotient  <= r_neg_q ? -w_quo_nxt : w_quo_nxt;
          r_remainder <= r_neg_r ? -w_rem_nxt : w_rem_nxt;
          r_dbz       <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_iter_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter_hs
// Purpose  : Self-checking bench for div_iter_hs (EARLY_TERM 0 and 1 instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_div_iter_hs;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, is_signed;
  logic [31:0] dividend, divisor;
  bit          cur;

  logic        in_ready0, out_valid0, dbz0, busy0;
  logic        in_ready1, out_valid1, dbz1, busy1;
  logic [31:0] q0, r0, q1, r1;

  logic        in_ready_s, out_valid_s, dbz_s, busy_s;
  logic [31:0] q_s, r_s;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q, exp_r;
  logic        exp_dbz;
  int          exp_lat;

  always #5 clk = ~clk;

  assign in_ready_s  = cur ? in_ready1  : in_ready0;
  assign out_valid_s = cur ? out_valid1 : out_valid0;
  assign dbz_s       = cur ? dbz1       : dbz0;
  assign busy_s      = cur ? busy1      : busy0;
  assign q_s         = cur ? q1         : q0;
  assign r_s         = cur ? r1         : r0;

  div_iter_hs #(.WIDTH(32), .EARLY_TERM(0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid & ~cur), .in_ready(in_ready0), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid0), .out_ready(out_ready),
    .quotient(q0), .remainder(r0), .div_by_zero(dbz0), .busy(busy0)
  );

  div_iter_hs #(.WIDTH(32), .EARLY_TERM(1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid & cur), .in_ready(in_ready1), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid1), .out_ready(out_ready),
    .quotient(q1), .remainder(r1), .div_by_zero(dbz1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division plus the bit-length of |dividend|
  task automatic model(input bit et, input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [31:0] m;
    int          nb;
    if (b == 32'd0) begin
      exp_q = 32'hFFFF_FFFF; exp_r = a; exp_dbz = 1'b1; exp_lat = 1;
      return;
    end
    exp_dbz = 1'b0;
    if (sg) begin
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      exp_q = 32'(sa / sb);
      exp_r = 32'(sa % sb);
      m     = a[31] ? 32'(-sa) : a;
    end else begin
      exp_q = a / b;
      exp_r = a % b;
      m     = a;
    end
    nb = 0;
    while (m != 32'd0) begin
      nb++;
      m = m >> 1;
    end
    exp_lat = et ? (((nb < 1) ? 1 : nb) + 1) : 33;
  endtask

  task automatic issue(input bit s, input bit sg, input logic [31:0] a, input logic [31:0] b,
                       input bit pop);
    @(negedge clk);
    cur = s; is_signed = sg; dividend = a; divisor = b;
    in_valid = 1'b1; out_ready = pop;
    #1;
    chk("in_ready_at_issue", in_ready_s, 1);
    model(s, sg, a, b);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
  endtask

  task automatic wait_result(input string tag);
    int k;
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid_s) break;
    end
    chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
    chk({tag, "_q"}, q_s, exp_q);
    chk({tag, "_r"}, r_s, exp_r);
    chk({tag, "_dbz"}, dbz_s, exp_dbz);
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_after_pop", out_valid_s, 0);
  endtask

  task automatic run(input string tag, input bit s, input bit sg,
                     input logic [31:0] a, input logic [31:0] b);
    issue(s, sg, a, b, 1'b0);
    wait_result(tag);
    pop();
  endtask

  initial begin
    int hits;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    is_signed = 1'b0; dividend = '0; divisor = '0; cur = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_q0", q0, 0);
    chk("rst_r0", r0, 0);
    chk("rst_dbz0", dbz0, 0);
    chk("rst_valid0", out_valid0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_ready0", in_ready0, 1);
    chk("rst_valid1", out_valid1, 0);
    chk("rst_ready1", in_ready1, 1);

    run("divu_100_7", 1'b0, 1'b0, 32'd100, 32'd7);
    run("div_m7_2",   1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run("div_7_m2",   1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
    run("divu_big",   1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10);
    run("div_ovf",    1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run("div_min_1",  1'b0, 1'b1, 32'h8000_0000, 32'd1);
    run("divu_5_0",   1'b1, 1'b0, 32'd5, 32'd0);
    run("divu_6_3",   1'b1, 1'b0, 32'd6, 32'd3);
    run("div_m9_0",   1'b0, 1'b1, 32'hFFFF_FFF7, 32'd0);

    // Result held under back-pressure, then popped together with a new accept
    issue(1'b1, 1'b0, 32'd3, 32'd1, 1'b0);
    wait_result("divu_3_1");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_q", q_s, exp_q);
      chk("hold_valid", out_valid_s, 1);
      chk("hold_in_ready", in_ready_s, 0);
    end
    issue(1'b1, 1'b0, 32'd8, 32'd2, 1'b1);
    wait_result("divu_8_2_b2b");
    pop();

    // Flush mid-operation
    issue(1'b0, 1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", out_valid_s, 0);
    chk("flush_busy", busy_s, 0);
    chk("flush_in_ready", in_ready_s, 1);
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_s) hits++;
    end
    chk("flush_no_result", 64'(hits), 0);
    run("divu_9_4_after_flush", 1'b0, 1'b0, 32'd9, 32'd4);

    // Reset mid-operation
    issue(1'b0, 1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mrst_q", q_s, 0);
    chk("mrst_r", r_s, 0);
    chk("mrst_dbz", dbz_s, 0);
    chk("mrst_valid", out_valid_s, 0);
    chk("mrst_busy", busy_s, 0);
    run("divu_9_4_after_reset", 1'b0, 1'b0, 32'd9, 32'd4);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      bit          s, sg;
      s  = 1'($urandom);
      sg = 1'($urandom);
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(0, 1) ? 32'd1 : 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: a = a >> $urandom_range(0, 31);
        default: ;
      endcase
      run("random", s, sg, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
